// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    localparam int D_WIDTH = 16;
    localparam int A_WIDTH = 8;
    localparam int LAT     = 1;
    localparam int STARVE  = 4;

endpackage

// File: rtl/ls_reg.sv
// Load-enable capture register with synchronous clear.
// One-cycle latency from ld to q; no backpressure.
module ls_reg #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and data access.
// Request in IDLE completes 2+lat cycles later; requests wait while an access is in flight.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int d_width = D_WIDTH,
    parameter int a_width = A_WIDTH,
    parameter int lat     = LAT,
    parameter int starve  = STARVE
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               i_req,
    input  logic [a_width-1:0] i_addr,
    output logic [d_width-1:0] i_rdata,
    output logic               i_odv,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [a_width-1:0] d_addr,
    input  logic [d_width-1:0] d_wdata,
    output logic [d_width-1:0] d_rdata,
    output logic               d_odv,
    output logic               ram_en,
    output logic               ram_we,
    output logic [a_width-1:0] ram_addr,
    output logic [d_width-1:0] ram_wdata,
    input  logic [d_width-1:0] ram_rdata,
    output logic               busy
);

    localparam int SW = $clog2(starve + 1);
    localparam int WW = $clog2(lat + 1);

    state_t        state;
    gnt_t          owner;
    logic          lat_we;
    logic [SW-1:0] streak;
    logic [WW-1:0] wcnt;

    logic grant_d;
    logic grant_i;
    logic last_wait;
    logic i_ld;
    logic d_ld;

    always_comb begin
        grant_d   = d_req && (!i_req || (int'(streak) < starve));
        grant_i   = !grant_d && i_req;
        last_wait = (state == WAIT) && (wcnt == WW'(lat));
        i_ld      = last_wait && (owner == GNT_I);
        d_ld      = last_wait && (owner == GNT_D) && !lat_we;
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state     <= IDLE;
            owner     <= GNT_I;
            lat_we    <= 1'b0;
            streak    <= '0;
            wcnt      <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            i_odv     <= 1'b0;
            d_odv     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            i_odv  <= 1'b0;
            d_odv  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner     <= GNT_D;
                        lat_we    <= d_we;
                        ram_addr  <= d_addr;
                        ram_wdata <= d_wdata;
                        ram_en    <= 1'b1;
                        ram_we    <= d_we;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                        // Streak only grows while the fetch side is actually waiting.
                        if (!i_req)
                            streak <= '0;
                        else if (streak != SW'(starve))
                            streak <= streak + SW'(1);
                    end else if (grant_i) begin
                        owner    <= GNT_I;
                        lat_we   <= 1'b0;
                        ram_addr <= i_addr;
                        ram_en   <= 1'b1;
                        busy     <= 1'b1;
                        streak   <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= WW'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (wcnt == WW'(lat)) begin
                        state <= DONE;
                        if (owner == GNT_I)
                            i_odv <= 1'b1;
                        else
                            d_odv <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ls_reg #(.n(d_width)) u_i_rdata (
        .clk (g_clk),
        .clr (g_clr),
        .ld  (i_ld),
        .d   (ram_rdata),
        .q   (i_rdata)
    );

    ls_reg #(.n(d_width)) u_d_rdata (
        .clk (g_clk),
        .clr (g_clr),
        .ld  (d_ld),
        .d   (ram_rdata),
        .q   (d_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: lat=1 arbiter instance for arbitration/timing, lat=3 instance for mid-access reset.
module tb_mem_port_arbiter;

    logic g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int checks = 0;
    int errors = 0;

    logic clr1, clr3;

    logic        i_req, d_req, d_we, i_odv, d_odv, ram_en, ram_we, busy;
    logic [7:0]  i_addr, d_addr, ram_addr;
    logic [15:0] d_wdata, i_rdata, d_rdata, ram_wdata, ram_rdata;

    logic        i_req_3, d_req_3, d_we_3, i_odv_3, d_odv_3, ram_en_3, ram_we_3, busy_3;
    logic [7:0]  i_addr_3, d_addr_3, ram_addr_3;
    logic [15:0] d_wdata_3, i_rdata_3, d_rdata_3, ram_wdata_3, ram_rdata_3;

    logic        pre_we1, pre_we3;
    logic [7:0]  pre_addr;
    logic [15:0] pre_dat;
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] r3a, r3b;

    mem_port_arbiter #(.d_width(16), .a_width(8), .lat(1), .starve(4)) u_dut1 (
        .g_clk(g_clk), .g_clr(clr1),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_odv(i_odv),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_odv(d_odv),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.d_width(16), .a_width(8), .lat(3), .starve(4)) u_dut3 (
        .g_clk(g_clk), .g_clr(clr3),
        .i_req(i_req_3), .i_addr(i_addr_3), .i_rdata(i_rdata_3), .i_odv(i_odv_3),
        .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_rdata(d_rdata_3), .d_odv(d_odv_3),
        .ram_en(ram_en_3), .ram_we(ram_we_3), .ram_addr(ram_addr_3),
        .ram_wdata(ram_wdata_3), .ram_rdata(ram_rdata_3), .busy(busy_3)
    );

    // RAM models: one-cycle read path, and a three-stage read path.
    always @(posedge g_clk) begin
        if (pre_we1)
            mem1[pre_addr] <= pre_dat;
        else if (ram_en && ram_we)
            mem1[ram_addr] <= ram_wdata;
        ram_rdata <= mem1[ram_addr];
    end

    always @(posedge g_clk) begin
        if (pre_we3)
            mem3[pre_addr] <= pre_dat;
        else if (ram_en_3 && ram_we_3)
            mem3[ram_addr_3] <= ram_wdata_3;
        r3a         <= mem3[ram_addr_3];
        r3b         <= r3a;
        ram_rdata_3 <= r3b;
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic preload1(input logic [7:0] a, input logic [15:0] v);
        pre_addr = a; pre_dat = v; pre_we1 = 1'b1;
        tick();
        pre_we1 = 1'b0;
    endtask

    task automatic preload3(input logic [7:0] a, input logic [15:0] v);
        pre_addr = a; pre_dat = v; pre_we3 = 1'b1;
        tick();
        pre_we3 = 1'b0;
    endtask

    task automatic test_reset();
        clr1 = 1'b1; clr3 = 1'b1;
        tick(); tick();
        checks++; if ({ram_en, ram_we, i_odv, d_odv, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {ram_en, ram_we, i_odv, d_odv, busy}); end
        checks++; if ({i_rdata, d_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata}); end
        checks++; if ({ram_addr, ram_wdata} !== 24'h0) begin errors++; $display("FAIL reset_ram_bus: got %h want 0", {ram_addr, ram_wdata}); end
        checks++; if (u_dut1.streak !== 3'd0) begin errors++; $display("FAIL reset_streak: got %0d want 0", u_dut1.streak); end
        checks++; if ({ram_en_3, i_odv_3, d_odv_3, busy_3} !== 4'b0) begin errors++; $display("FAIL reset_ctrl3: got %b want 0000", {ram_en_3, i_odv_3, d_odv_3, busy_3}); end
        clr1 = 1'b0; clr3 = 1'b0;
        tick();
    endtask

    task automatic test_single_instr();
        preload1(8'h10, 16'hBEEF);
        i_req = 1'b1; i_addr = 8'h10;
        tick();
        checks++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h10}) begin errors++; $display("FAIL single_issue: got en=%b we=%b addr=%h want 1 0 10", ram_en, ram_we, ram_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        i_addr = 8'h99;
        tick();
        checks++; if (i_odv !== 1'b0) begin errors++; $display("FAIL single_wait_odv: got %b want 0", i_odv); end
        tick();
        checks++; if ({i_odv, i_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL single_done: got odv=%b rdata=%h want 1 beef", i_odv, i_rdata); end
        i_req = 1'b0;
        tick();
        checks++; if ({busy, i_odv} !== 2'b00) begin errors++; $display("FAIL single_idle: got busy=%b odv=%b want 0 0", busy, i_odv); end
    endtask

    task automatic test_write_read();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'h1234;
        for (int c = 1; c <= 7; c++) begin
            tick();
            checks++; if (ram_we !== (c == 1)) begin errors++; $display("FAIL wr_ram_we c%0d: got %b want %b", c, ram_we, (c == 1)); end
            checks++; if (d_odv !== (c == 3 || c == 7)) begin errors++; $display("FAIL wr_d_odv c%0d: got %b want %b", c, d_odv, (c == 3 || c == 7)); end
            checks++; if (i_odv !== 1'b0) begin errors++; $display("FAIL wr_i_odv c%0d: got %b want 0", c, i_odv); end
            if (c == 1) begin
                checks++; if ({ram_addr, ram_wdata} !== {8'h20, 16'h1234}) begin errors++; $display("FAIL wr_bus: got %h %h want 20 1234", ram_addr, ram_wdata); end
                d_wdata = 16'hFFFF;
            end
            if (c == 3) begin
                checks++; if (d_rdata !== 16'h0) begin errors++; $display("FAIL wr_rdata_untouched: got %h want 0", d_rdata); end
                d_we = 1'b0;
            end
            if (c == 7) begin
                checks++; if (d_rdata !== 16'h1234) begin errors++; $display("FAIL rd_rdata: got %h want 1234", d_rdata); end
                d_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_simultaneous();
        preload1(8'h11, 16'hA5A5);
        preload1(8'h21, 16'h5A5A);
        i_req = 1'b1; i_addr = 8'h11;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h21;
        for (int c = 1; c <= 7; c++) begin
            tick();
            checks++; if ({d_odv, i_odv} !== {(c == 3), (c == 7)}) begin errors++; $display("FAIL simul_odv c%0d: got d=%b i=%b want %b %b", c, d_odv, i_odv, (c == 3), (c == 7)); end
            if (c == 3) begin
                checks++; if (d_rdata !== 16'h5A5A) begin errors++; $display("FAIL simul_d_rdata: got %h want 5a5a", d_rdata); end
                d_req = 1'b0;
            end
            if (c == 7) begin
                checks++; if (i_rdata !== 16'hA5A5) begin errors++; $display("FAIL simul_i_rdata: got %h want a5a5", i_rdata); end
                i_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_starvation();
        int n;
        logic [7:0] ga [6];
        logic [2:0] gs [6];
        logic [7:0] ea [6];
        int         es [6];
        ea = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h40, 8'h30};
        es = '{1, 2, 3, 4, 0, 0};
        n = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
        i_req = 1'b1; i_addr = 8'h40;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (ram_en) begin
                ga[n] = ram_addr; gs[n] = u_dut1.streak; n++;
            end
            if (i_odv) i_req = 1'b0;
            if (n == 6) d_req = 1'b0;
        end
        d_req = 1'b0; i_req = 1'b0;
        checks++; if (n !== 6) begin errors++; $display("FAIL starve_grant_count: got %0d want 6", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (ga[k] !== ea[k]) begin errors++; $display("FAIL starve_order g%0d: got addr %h want %h", k, ga[k], ea[k]); end
            checks++; if ({29'd0, gs[k]} !== es[k]) begin errors++; $display("FAIL starve_streak g%0d: got %0d want %0d", k, gs[k], es[k]); end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        int k;
        logic [7:0]  a [3];
        logic [15:0] v [3];
        a = '{8'h50, 8'h51, 8'h52};
        v = '{16'h1111, 16'h2222, 16'h3333};
        for (int j = 0; j < 3; j++) preload1(a[j], v[j]);
        k = 0;
        i_req = 1'b1; i_addr = a[0];
        for (int c = 1; c <= 11; c++) begin
            tick();
            checks++; if (i_odv !== (c % 4 == 3)) begin errors++; $display("FAIL b2b_odv c%0d: got %b want %b", c, i_odv, (c % 4 == 3)); end
            if (i_odv && k < 3) begin
                checks++; if (i_rdata !== v[k]) begin errors++; $display("FAIL b2b_rdata %0d: got %h want %h", k, i_rdata, v[k]); end
                k++;
                if (k < 3) i_addr = a[k];
                else i_req = 1'b0;
            end
        end
        i_req = 1'b0;
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", k); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int seen;
        preload3(8'h60, 16'hCAFE);
        preload3(8'h61, 16'hBEAD);
        i_req_3 = 1'b1; i_addr_3 = 8'h60;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++; if (i_odv_3 !== (c == 5)) begin errors++; $display("FAIL lat3_odv c%0d: got %b want %b", c, i_odv_3, (c == 5)); end
            if (c == 5) begin
                checks++; if (i_rdata_3 !== 16'hCAFE) begin errors++; $display("FAIL lat3_rdata: got %h want cafe", i_rdata_3); end
                i_req_3 = 1'b0;
            end
        end
        tick();
        i_req_3 = 1'b1; i_addr_3 = 8'h61;
        tick(); tick(); tick();
        clr3 = 1'b1; i_req_3 = 1'b0;
        tick();
        checks++; if ({busy_3, i_odv_3, d_odv_3, ram_en_3} !== 4'b0) begin errors++; $display("FAIL midrst_ctrl: got %b want 0000", {busy_3, i_odv_3, d_odv_3, ram_en_3}); end
        checks++; if ({i_rdata_3, d_rdata_3} !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", {i_rdata_3, d_rdata_3}); end
        clr3 = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (i_odv_3 || d_odv_3 || busy_3) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", seen); end
        i_req_3 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++; if (i_odv_3 !== (c == 5)) begin errors++; $display("FAIL postrst_odv c%0d: got %b want %b", c, i_odv_3, (c == 5)); end
            if (c == 5) begin
                checks++; if (i_rdata_3 !== 16'hBEAD) begin errors++; $display("FAIL postrst_rdata: got %h want bead", i_rdata_3); end
                i_req_3 = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        clr1 = 1'b1; clr3 = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req_3 = 1'b0; i_addr_3 = '0; d_req_3 = 1'b0; d_we_3 = 1'b0; d_addr_3 = '0; d_wdata_3 = '0;
        pre_we1 = 1'b0; pre_we3 = 1'b0; pre_addr = '0; pre_dat = '0;
        test_reset();
        test_single_instr();
        test_write_read();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
